// File: rtl/circle_intersect_seq.sv
// Circle-circle intersection engine: returns both crossing points of circles
// B and C as exact numerators over the shared denominator 2*d^2, using a
// bit-serial restoring square root. No division is performed.
module circle_intersect_seq #(
    parameter int unsigned N = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [N-1:0]     xB,
    input  logic signed [N-1:0]     yB,
    input  logic signed [N-1:0]     xC,
    input  logic signed [N-1:0]     yC,
    input  logic        [N:0]       rB,
    input  logic        [N:0]       rC,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [3*N+5:0]   x1n,
    output logic signed [3*N+5:0]   y1n,
    output logic signed [3*N+5:0]   x2n,
    output logic signed [3*N+5:0]   y2n,
    output logic        [2*N+2:0]   den,
    output logic                    no_int,
    output logic                    tangent,
    output logic                    coincident
);
    localparam int unsigned CW   = N + 1;
    localparam int unsigned DW   = 2 * N + 2;
    localparam int unsigned KW   = 2 * N + 4;
    localparam int unsigned SW   = 4 * N + 7;
    localparam int unsigned RW   = 2 * N + 3;
    localparam int unsigned NW   = 3 * N + 6;
    localparam int unsigned RADW = 2 * RW;
    localparam int unsigned REMW = RW + 3;
    localparam int unsigned CNTW = $clog2(RW + 1);

    typedef enum logic [2:0] {IDLE, PRE, KS, SQRT, POST, DONE} state_t;

    state_t state, next_state;
    logic   ld_in, ld_pre, ld_ks, sqrt_step, ld_post;

    logic signed [N-1:0]  xb_q, yb_q, xc_q, yc_q;
    logic        [N:0]    rb_q, rc_q;
    logic signed [CW-1:0] dx_q, dy_q;
    logic        [DW-1:0] d2_q, rb2_q, rc2_q;
    logic signed [KW-1:0] k_q;
    logic signed [SW-1:0] s_q;
    logic [RADW-1:0]      rad_q;
    logic [REMW-1:0]      rem_q;
    logic [RW-1:0]        root_q;
    logic [CNTW-1:0]      cnt_q;

    logic signed [CW-1:0] dx_c, dy_c;
    logic signed [DW-1:0] dxw, dyw;
    logic        [DW-1:0] d2_c, rb2_c, rc2_c;
    logic signed [KW-1:0] k_c;
    logic signed [SW-1:0] s_c;
    logic [REMW-1:0]      rem_sh, trial, rem_n;
    logic [RW-1:0]        root_n;
    logic signed [NW-1:0] d2w, xbw, ybw, kw, dxnw, dynw, rw, bx, by;
    logic signed [NW-1:0] x1_c, y1_c, x2_c, y2_c;

    // State register; reset returns to IDLE from any state
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic; degenerate cases skip the square root and go via POST
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (in_valid) next_state = PRE;
            PRE:  next_state = KS;
            KS:   next_state = (d2_q == '0 || s_c[SW-1]) ? POST : SQRT;
            SQRT: if (cnt_q == CNTW'(RW - 1)) next_state = POST;
            POST: next_state = DONE;
            DONE: if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath load strobes decoded from the current state
    always_comb begin
        ld_in     = 1'b0;
        ld_pre    = 1'b0;
        ld_ks     = 1'b0;
        sqrt_step = 1'b0;
        ld_post   = 1'b0;
        case (state)
            IDLE: ld_in     = in_valid;
            PRE:  ld_pre    = 1'b1;
            KS:   ld_ks     = 1'b1;
            SQRT: sqrt_step = 1'b1;
            POST: ld_post   = 1'b1;
            default: ;
        endcase
    end

    // Registered handshake outputs follow the upcoming state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (next_state == IDLE);
            out_valid <= (next_state == DONE);
        end
    end

    // Centre deltas, squared distance and squared radii
    always_comb begin
        dx_c  = CW'(xc_q) - CW'(xb_q);
        dy_c  = CW'(yc_q) - CW'(yb_q);
        dxw   = DW'(dx_c);
        dyw   = DW'(dy_c);
        d2_c  = DW'(dxw * dxw + dyw * dyw);
        rb2_c = DW'(rb_q) * DW'(rb_q);
        rc2_c = DW'(rc_q) * DW'(rc_q);
    end

    // k and the square-root argument s = 4*d2*rB^2 - k^2
    always_comb begin
        k_c = $signed(KW'(rb2_q)) - $signed(KW'(rc2_q)) + $signed(KW'(d2_q));
        s_c = $signed((SW'(d2_q) * SW'(rb2_q)) << 2) - SW'(k_c) * SW'(k_c);
    end

    // One restoring square-root step: bring down two radicand bits, try subtract
    always_comb begin
        rem_sh = REMW'({rem_q, rad_q[RADW-1 -: 2]});
        trial  = REMW'({root_q, 2'b01});
        if (rem_sh >= trial) begin
            rem_n  = rem_sh - trial;
            root_n = {root_q[RW-2:0], 1'b1};
        end else begin
            rem_n  = rem_sh;
            root_n = {root_q[RW-2:0], 1'b0};
        end
    end

    // Point numerators from the exact integer terms
    always_comb begin
        d2w  = $signed(NW'(d2_q));
        xbw  = NW'(xb_q);
        ybw  = NW'(yb_q);
        kw   = NW'(k_q);
        dxnw = NW'(dx_q);
        dynw = NW'(dy_q);
        rw   = $signed(NW'(root_q));
        bx   = (d2w + d2w) * xbw + kw * dxnw;
        by   = (d2w + d2w) * ybw + kw * dynw;
        x1_c = bx - rw * dynw;
        y1_c = by + rw * dxnw;
        x2_c = bx + rw * dynw;
        y2_c = by - rw * dxnw;
    end

    // Datapath and result registers; results hold until the next POST
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xb_q <= '0; yb_q <= '0; xc_q <= '0; yc_q <= '0;
            rb_q <= '0; rc_q <= '0;
            dx_q <= '0; dy_q <= '0; d2_q <= '0; rb2_q <= '0; rc2_q <= '0;
            k_q <= '0; s_q <= '0;
            rad_q <= '0; rem_q <= '0; root_q <= '0; cnt_q <= '0;
            x1n <= '0; y1n <= '0; x2n <= '0; y2n <= '0; den <= '0;
            no_int <= 1'b0; tangent <= 1'b0; coincident <= 1'b0;
        end else begin
            if (ld_in) begin
                xb_q <= xB; yb_q <= yB; xc_q <= xC; yc_q <= yC;
                rb_q <= rB; rc_q <= rC;
            end
            if (ld_pre) begin
                dx_q  <= dx_c;
                dy_q  <= dy_c;
                d2_q  <= d2_c;
                rb2_q <= rb2_c;
                rc2_q <= rc2_c;
            end
            if (ld_ks) begin
                k_q    <= k_c;
                s_q    <= s_c;
                rad_q  <= RADW'(s_c);
                rem_q  <= '0;
                root_q <= '0;
                cnt_q  <= '0;
            end
            if (sqrt_step) begin
                rem_q  <= rem_n;
                root_q <= root_n;
                rad_q  <= rad_q << 2;
                cnt_q  <= cnt_q + CNTW'(1);
            end
            if (ld_post) begin
                coincident <= (d2_q == '0);
                no_int     <= (d2_q != '0) && s_q[SW-1];
                tangent    <= (d2_q != '0) && (s_q == '0);
                if (d2_q == '0 || s_q[SW-1]) begin
                    x1n <= '0; y1n <= '0; x2n <= '0; y2n <= '0; den <= '0;
                end else begin
                    x1n <= x1_c;
                    y1n <= y1_c;
                    x2n <= x2_c;
                    y2n <= y2_c;
                    den <= {d2_q, 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_circle_intersect_seq.sv
// Bench for circle_intersect_seq: directed vectors checked against an
// arithmetic model of the intersection formulas, with literal pins on the model.
module tb_circle_intersect_seq;
    localparam int N = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic signed [N-1:0]   xB = '0, yB = '0, xC = '0, yC = '0;
    logic        [N:0]     rB = '0, rC = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic signed [3*N+5:0] x1n, y1n, x2n, y2n;
    logic        [2*N+2:0] den;
    logic                  no_int, tangent, coincident;

    typedef struct {
        longint x1, y1, x2, y2, den, r;
        bit     ni, tg, co;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    circle_intersect_seq #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .xB(xB), .yB(yB), .xC(xC), .yC(yC), .rB(rB), .rC(rC),
        .out_valid(out_valid), .out_ready(out_ready),
        .x1n(x1n), .y1n(y1n), .x2n(x2n), .y2n(y2n), .den(den),
        .no_int(no_int), .tangent(tangent), .coincident(coincident)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Geometry model: plain integer arithmetic and a bitwise floor square root
    function automatic res_t model(input longint xb, yb, xc, yc, rb, rc);
        res_t   m;
        longint dx, dy, d2, k, s, t;
        m = '{x1: 0, y1: 0, x2: 0, y2: 0, den: 0, r: 0, ni: 0, tg: 0, co: 0};
        dx = xc - xb;
        dy = yc - yb;
        d2 = dx * dx + dy * dy;
        k  = rb * rb - rc * rc + d2;
        s  = 4 * d2 * rb * rb - k * k;
        if (d2 == 0) begin
            m.co = 1'b1;
        end else if (s < 0) begin
            m.ni = 1'b1;
        end else begin
            for (int b = 31; b >= 0; b--) begin
                t = m.r | (longint'(1) << b);
                if (t * t <= s) m.r = t;
            end
            m.tg  = (s == 0);
            m.x1  = 2 * d2 * xb + k * dx - m.r * dy;
            m.y1  = 2 * d2 * yb + k * dy + m.r * dx;
            m.x2  = 2 * d2 * xb + k * dx + m.r * dy;
            m.y2  = 2 * d2 * yb + k * dy - m.r * dx;
            m.den = 2 * d2;
        end
        return m;
    endfunction

    // Result checker: every valid cycle must match the oldest outstanding result
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("stale_out_valid", 1, 0);
            end else begin
                chk("x1n", longint'(x1n), exp_q[0].x1);
                chk("y1n", longint'(y1n), exp_q[0].y1);
                chk("x2n", longint'(x2n), exp_q[0].x2);
                chk("y2n", longint'(y2n), exp_q[0].y2);
                chk("den", longint'(den), exp_q[0].den);
                chk("no_int", longint'(no_int), longint'(exp_q[0].ni));
                chk("tangent", longint'(tangent), longint'(exp_q[0].tg));
                chk("coincident", longint'(coincident), longint'(exp_q[0].co));
                chk("in_ready_busy", longint'(in_ready), 0);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic run(input int xb, yb, xc, yc, rb, rc, input int hold, input bit pulse);
        res_t e;
        int   n, lat, lat_req;
        e = model(xb, yb, xc, yc, rb, rc);
        lat_req = (e.co || e.ni) ? 3 : 2 * N + 6;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_wait", longint'(in_ready), 1);
        xB = N'(xb); yB = N'(yb); xC = N'(xc); yC = N'(yc);
        rB = (N+1)'(rb); rC = (N+1)'(rc);
        in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        in_valid = 1'b0;
        chk("in_ready_after_accept", longint'(in_ready), 0);
        if (pulse) begin
            xB = 8'sd20; yB = -8'sd20; xC = 8'sd1; yC = 8'sd2; rB = 9'd100; rC = 9'd3;
            in_valid = 1'b1;
        end
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
            if (lat == 4) in_valid = 1'b0;
        end
        chk("latency", lat, lat_req);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_out_valid", longint'(out_valid), 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_after_hs", longint'(out_valid), 0);
        chk("in_ready_after_hs", longint'(in_ready), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        res_t m;
        int   seen;

        // Literal pins on the model
        m = model(0, 0, 6, 0, 5, 5);
        chk("pin_two_x1", m.x1, 216);
        chk("pin_two_y1", m.y1, 288);
        chk("pin_two_y2", m.y2, -288);
        chk("pin_two_den", m.den, 72);
        m = model(0, 0, 5, 0, 3, 2);
        chk("pin_tan_flag", longint'(m.tg), 1);
        chk("pin_tan_x1", m.x1, 150);
        m = model(-32, 108, -16, -111, 215, 236);
        chk("pin_sqrt_r", m.r, 86104);
        chk("pin_sqrt_x1", m.x1, 16390824);
        chk("pin_sqrt_y1", m.y1, 3307162);
        chk("pin_sqrt_x2", m.x2, -21322728);
        chk("pin_sqrt_den", m.den, 96434);
        m = model(-7, 12, -7, 12, 4, 9);
        chk("pin_coin_ni", longint'(m.ni), 0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_x1n", longint'(x1n), 0);
        chk("rst_den", longint'(den), 0);
        chk("rst_flags", longint'({no_int, tangent, coincident}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(0, 0, 6, 0, 5, 5, 0, 1'b0);
        run(0, 0, 5, 0, 3, 2, 10, 1'b1);
        run(0, 0, 10, 0, 1, 1, 0, 1'b0);
        run(-7, 12, -7, 12, 4, 9, 2, 1'b0);
        run(-32, 108, -16, -111, 215, 236, 0, 1'b0);
        run(3, -4, -2, 5, 9, 7, 0, 1'b1);

        // Reset in the middle of the square root discards the operation
        xB = 8'sd0; yB = 8'sd0; xC = 8'sd6; yC = 8'sd0; rB = 9'd5; rC = 9'd5;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_in_ready", longint'(in_ready), 1);
        chk("midrst_x1n", longint'(x1n), 0);
        chk("midrst_den", longint'(den), 0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("rst_held_in_ready", longint'(in_ready), 1);
        in_valid = 1'b0;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("no_stale_result", seen, 0);
        chk("idle_after_rst", longint'(in_ready), 1);

        run(-32, 108, -16, -111, 215, 236, 3, 1'b0);
        run(-100, 50, 90, -60, 200, 150, 0, 1'b0);

        repeat (3) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
